// File: rtl/pc_sequencer_pkg.sv
// Shared declarations for the PC sequencer slice.
//   WORD_SIZE    default datapath width
//   state_t      sequencer state (RUN / FLUSH / FAULT), legacy-encoded
//   redirect_t   which redirect source won arbitration this cycle
//   sext_to_word sign-extend a 12/13/21-bit immediate to a full word
package pc_seq_pkg;

  localparam int unsigned WORD_SIZE = 32;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  typedef enum logic [1:0] {
    RUN   = ST_RUN,
    FLUSH = ST_FLUSH,
    FAULT = ST_FAULT
  } state_t;

  typedef enum logic [1:0] {
    RD_NONE,
    RD_BR,
    RD_JAL,
    RD_JALR
  } redirect_t;

  // imm carries the immediate in its low 'width' bits; upper bits are don't-care.
  function automatic logic [WORD_SIZE-1:0] sext_to_word(input logic [20:0] imm,
                                                        input int unsigned width);
    logic signed [WORD_SIZE-1:0] t;
    t = WORD_SIZE'(imm) << (WORD_SIZE - width);
    return t >>> (WORD_SIZE - width);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Execute-stage control / fetch-address bundle for pc_sequencer.
//   master : execute stage side (drives requests, reads fetch address)
//   slave  : the sequencer itself
interface pc_sequencer_if #(
  parameter int unsigned WORD_SIZE = pc_seq_pkg::WORD_SIZE
);
  logic                 stall;
  logic                 br_taken;
  logic [12:0]          br_offset;
  logic                 jal_req;
  logic [20:0]          jal_offset;
  logic                 jalr_req;
  logic [WORD_SIZE-1:0] jalr_base;
  logic [11:0]          jalr_imm;
  logic [WORD_SIZE-1:0] ex_pc;
  logic [WORD_SIZE-1:0] pc;
  logic                 pc_valid;
  logic                 flush;
  logic [WORD_SIZE-1:0] link_value;
  logic                 misalign_fault;

  modport master (
    output stall, br_taken, br_offset, jal_req, jal_offset,
           jalr_req, jalr_base, jalr_imm, ex_pc,
    input  pc, pc_valid, flush, link_value, misalign_fault
  );

  modport slave (
    input  stall, br_taken, br_offset, jal_req, jal_offset,
           jalr_req, jalr_base, jalr_imm, ex_pc,
    output pc, pc_valid, flush, link_value, misalign_fault
  );
endinterface

// File: rtl/pc_sequencer_target_adder.sv
// Shared redirect-target adder (combinational).
//   base    : ex_pc or rs1
//   offset  : already sign-extended immediate
//   clr_lsb : clear bit 0 of the sum (JALR)
//   target  : resulting redirect address, modulo 2^WORD_SIZE
module target_adder #(
  parameter int unsigned WORD_SIZE = pc_seq_pkg::WORD_SIZE
) (
  input  logic [WORD_SIZE-1:0] base,
  input  logic [WORD_SIZE-1:0] offset,
  input  logic                 clr_lsb,
  output logic [WORD_SIZE-1:0] target
);
  logic [WORD_SIZE-1:0] sum;

  assign sum    = base + offset;
  assign target = {sum[WORD_SIZE-1:1], sum[0] & ~clr_lsb};
endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: sequential advance, JAL / branch / JALR redirects,
// post-redirect flush window and sticky misalignment fault.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : execute-stage requests in, fetch address / status out
module pc_sequencer #(
  parameter int unsigned          WORD_SIZE    = pc_seq_pkg::WORD_SIZE,
  parameter logic [WORD_SIZE-1:0] RESET_PC     = '0,
  parameter int unsigned          FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);
  import pc_seq_pkg::*;

  state_t               state;
  redirect_t            rd_kind;
  logic [WORD_SIZE-1:0] pc_q;
  logic                 pc_valid_q;
  logic                 flush_q;
  logic                 fault_q;
  logic [2:0]           flush_cnt;

  logic [WORD_SIZE-1:0] add_base;
  logic [WORD_SIZE-1:0] add_off;
  logic                 add_clr;
  logic [WORD_SIZE-1:0] target;
  logic                 misaligned;

  // Lower-priority requests are simply dropped.
  always_comb begin
    rd_kind = RD_NONE;
    if (bus.jalr_req)      rd_kind = RD_JALR;
    else if (bus.jal_req)  rd_kind = RD_JAL;
    else if (bus.br_taken) rd_kind = RD_BR;
  end

  always_comb begin
    add_base = bus.ex_pc;
    add_off  = WORD_SIZE'($signed(sext_to_word(21'(bus.br_offset), 13)));
    add_clr  = 1'b0;
    case (rd_kind)
      RD_JALR: begin
        add_base = bus.jalr_base;
        add_off  = WORD_SIZE'($signed(sext_to_word(21'(bus.jalr_imm), 12)));
        add_clr  = 1'b1;
      end
      RD_JAL:  add_off = WORD_SIZE'($signed(sext_to_word(bus.jal_offset, 21)));
      default: ;
    endcase
  end

  target_adder #(.WORD_SIZE(WORD_SIZE)) u_target_adder (
    .base    (add_base),
    .offset  (add_off),
    .clr_lsb (add_clr),
    .target  (target)
  );

  // JALR already has bit 0 cleared, so one check covers all three kinds.
  assign misaligned = |target[1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RUN;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b1;
      flush_q    <= 1'b0;
      fault_q    <= 1'b0;
      flush_cnt  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (rd_kind != RD_NONE) begin
            flush_q <= 1'b1;
            if (misaligned) begin
              fault_q    <= 1'b1;
              pc_valid_q <= 1'b0;
              state      <= FAULT;
            end else begin
              pc_q      <= target;
              flush_cnt <= 3'(FLUSH_CYCLES);
              state     <= FLUSH;
            end
          end else if (!bus.stall) begin
            pc_q <= pc_q + WORD_SIZE'(4);
          end
        end
        FLUSH: begin
          if (!bus.stall) pc_q <= pc_q + WORD_SIZE'(4);
          // Counter runs even while stalled; last decrement drops flush.
          flush_cnt <= flush_cnt - 3'd1;
          if (flush_cnt == 3'd1) begin
            flush_q <= 1'b0;
            state   <= RUN;
          end
        end
        FAULT: ;
        default: begin
          fault_q    <= 1'b1;
          pc_valid_q <= 1'b0;
          flush_q    <= 1'b1;
          state      <= FAULT;
        end
      endcase
    end
  end

  assign bus.pc             = pc_q;
  assign bus.pc_valid       = pc_valid_q;
  assign bus.flush          = flush_q;
  assign bus.misalign_fault = fault_q;
  assign bus.link_value     = bus.ex_pc + WORD_SIZE'(4);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  localparam int FC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.WORD_SIZE(32)) bus ();

  pc_sequencer #(.WORD_SIZE(32), .RESET_PC(32'h0), .FLUSH_CYCLES(FC)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // Reference model: remaining flush cycles + fault flag.
  logic [31:0] m_pc;
  logic        m_valid, m_flush, m_fault;
  int          m_left;

  task automatic model_step();
    logic [31:0] t;
    bit          redir;
    if (!rst_n) begin
      m_pc = 32'h0; m_valid = 1; m_flush = 0; m_fault = 0; m_left = 0;
    end else if (m_fault) begin
      // frozen
    end else if (m_left > 0) begin
      if (!bus.stall) m_pc = m_pc + 32'd4;
      m_left--;
      m_flush = (m_left > 0);
    end else begin
      redir = 1;
      if (bus.jalr_req)      t = (bus.jalr_base + 32'($signed(bus.jalr_imm))) & 32'hFFFF_FFFE;
      else if (bus.jal_req)  t = bus.ex_pc + 32'($signed(bus.jal_offset));
      else if (bus.br_taken) t = bus.ex_pc + 32'($signed(bus.br_offset));
      else begin redir = 0; t = '0; end
      if (redir) begin
        m_flush = 1;
        if (t % 4 != 0) begin
          m_fault = 1; m_valid = 0;
        end else begin
          m_pc = t; m_left = FC;
        end
      end else if (!bus.stall) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input logic stall_v);
    bus.stall = stall_v; bus.br_taken = 0; bus.br_offset = '0; bus.jal_req = 0;
    bus.jal_offset = '0; bus.jalr_req = 0; bus.jalr_base = '0; bus.jalr_imm = '0;
    bus.ex_pc = '0;
  endtask

  task automatic do_reset();
    idle(0); rst_n = 0; tick(); rst_n = 1;
  endtask

  task automatic test_reset();
    idle(0);
    rst_n = 0; tick();
    n_checks++;
    if ({bus.pc, bus.pc_valid, bus.flush, bus.misalign_fault} !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got pc=%h v=%b f=%b mf=%b want pc=0 v=1 f=0 mf=0",
               bus.pc, bus.pc_valid, bus.flush, bus.misalign_fault);
    end
    rst_n = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if ({bus.pc, bus.pc_valid, bus.flush} !== {32'(4 * i), 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_seq[%0d]: got pc=%h v=%b f=%b want pc=%h v=1 f=0",
                 i, bus.pc, bus.pc_valid, bus.flush, 32'(4 * i));
      end
    end
  endtask

  task automatic test_jalr_misalign();
    do_reset();
    idle(1); bus.jal_req = 1; bus.ex_pc = 32'hF0; bus.jal_offset = 21'h10; tick();
    idle(1); tick(); tick();
    n_checks++;
    if ({bus.pc, bus.flush} !== {32'h100, 1'b0}) begin
      n_fail++;
      $display("FAIL jalr_setup: got pc=%h f=%b want pc=00000100 f=0", bus.pc, bus.flush);
    end
    idle(0); bus.jalr_req = 1; bus.jalr_base = 32'h2003; bus.jalr_imm = 12'hFFF; tick();
    n_checks++;
    if ({bus.pc, bus.pc_valid, bus.flush, bus.misalign_fault} !== {32'h100, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL jalr_misalign: got pc=%h v=%b f=%b mf=%b want pc=00000100 v=0 f=1 mf=1",
               bus.pc, bus.pc_valid, bus.flush, bus.misalign_fault);
    end
    do_reset();
    idle(0); bus.jalr_req = 1; bus.jalr_base = 32'h2005; bus.jalr_imm = 12'hFFF; tick();
    n_checks++;
    if ({bus.pc, bus.flush, bus.misalign_fault} !== {32'h2004, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL jalr_aligned: got pc=%h f=%b mf=%b want pc=00002004 f=1 mf=0",
               bus.pc, bus.flush, bus.misalign_fault);
    end
    idle(0);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (bus.flush !== (i == 0)) begin
        n_fail++;
        $display("FAIL jalr_flush_len[%0d]: got flush=%b want %b", i, bus.flush, i == 0);
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    idle(0); bus.jal_req = 1; bus.br_taken = 1; bus.ex_pc = 32'h40;
    bus.jal_offset = 21'h000100; bus.br_offset = 13'h0010; tick();
    n_checks++;
    if ({bus.pc, bus.flush} !== {32'h140, 1'b1}) begin
      n_fail++;
      $display("FAIL jal_over_br: got pc=%h f=%b want pc=00000140 f=1", bus.pc, bus.flush);
    end
    idle(0); bus.br_taken = 1; bus.ex_pc = 32'h1000; bus.br_offset = 13'h0020;
    tick(); tick();
    n_checks++;
    if ({bus.pc, bus.flush} !== {32'h148, 1'b0}) begin
      n_fail++;
      $display("FAIL br_in_flush: got pc=%h f=%b want pc=00000148 f=0", bus.pc, bus.flush);
    end
  endtask

  task automatic test_stall_redirect();
    logic [31:0] held;
    do_reset();
    idle(1); bus.br_taken = 1; bus.ex_pc = 32'h80; bus.br_offset = 13'h1FF8; tick();
    n_checks++;
    if (bus.pc !== 32'h78) begin
      n_fail++;
      $display("FAIL stall_redirect: got pc=%h want 00000078", bus.pc);
    end
    idle(1); held = bus.pc;
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if ({bus.pc, bus.flush} !== {held, 1'b0}) begin
      n_fail++;
      $display("FAIL stall_hold: got pc=%h f=%b want pc=%h f=0", bus.pc, bus.flush, held);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    idle(1); bus.jalr_req = 1; bus.jalr_base = 32'hFFFF_FFFC; bus.jalr_imm = 12'h000; tick();
    idle(1); tick(); tick();
    idle(0); tick();
    n_checks++;
    if ({bus.pc, bus.misalign_fault, bus.pc_valid} !== {32'h0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL pc_wrap: got pc=%h mf=%b v=%b want pc=00000000 mf=0 v=1",
               bus.pc, bus.misalign_fault, bus.pc_valid);
    end
  endtask

  task automatic test_fault_hold();
    logic [34:0] snap;
    do_reset();
    idle(0); bus.br_taken = 1; bus.ex_pc = 32'h200; bus.br_offset = 13'h0006; tick();
    snap = {bus.pc, bus.pc_valid, bus.flush, bus.misalign_fault};
    n_checks++;
    if (snap[2:0] !== 3'b011) begin
      n_fail++;
      $display("FAIL fault_entry: got v/f/mf=%b want 011", snap[2:0]);
    end
    for (int i = 0; i < 5; i++) begin
      bus.stall = 1'($urandom); bus.br_taken = 1'($urandom); bus.br_offset = 13'($urandom);
      bus.jal_req = 1'($urandom); bus.jal_offset = 21'($urandom); bus.jalr_req = 1'($urandom);
      bus.jalr_base = $urandom; bus.jalr_imm = 12'($urandom); bus.ex_pc = $urandom;
      tick();
      n_checks++;
      if ({bus.pc, bus.pc_valid, bus.flush, bus.misalign_fault} !== snap) begin
        n_fail++;
        $display("FAIL fault_hold[%0d]: got %h want %h", i,
                 {bus.pc, bus.pc_valid, bus.flush, bus.misalign_fault}, snap);
      end
    end
    do_reset();
    n_checks++;
    if ({bus.pc, bus.pc_valid, bus.flush, bus.misalign_fault} !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL fault_reset: got pc=%h v=%b f=%b mf=%b want pc=0 v=1 f=0 mf=0",
               bus.pc, bus.pc_valid, bus.flush, bus.misalign_fault);
    end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    idle(0); bus.jal_req = 1; bus.ex_pc = 32'h300; bus.jal_offset = 21'h40; tick();
    idle(0); tick();
    rst_n = 0; tick(); rst_n = 1;
    n_checks++;
    if ({bus.pc, bus.flush} !== {32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_flush: got pc=%h f=%b want pc=0 f=0", bus.pc, bus.flush);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      bus.stall      = ($urandom_range(0, 3) == 0);
      bus.br_taken   = ($urandom_range(0, 5) == 0);
      bus.jal_req    = ($urandom_range(0, 7) == 0);
      bus.jalr_req   = ($urandom_range(0, 7) == 0);
      bus.ex_pc      = {$urandom_range(0, 32'hFFFF), 2'b00} + ($urandom_range(0, 15) == 0 ? 32'd2 : 32'd0);
      bus.br_offset  = {12'($urandom), 1'b0} & ($urandom_range(0, 9) == 0 ? 13'h1FFE : 13'h1FFC);
      bus.jal_offset = {20'($urandom), 1'b0} & ($urandom_range(0, 9) == 0 ? 21'h1FFFFE : 21'h1FFFFC);
      bus.jalr_base  = $urandom;
      bus.jalr_imm   = 12'($urandom);
      #1;
      n_checks++;
      if (bus.link_value !== bus.ex_pc + 32'd4) begin
        n_fail++;
        $display("FAIL link_value[%0d]: got %h want %h", i, bus.link_value, bus.ex_pc + 32'd4);
      end
      tick();
      n_checks++;
      if ({bus.pc, bus.pc_valid, bus.flush, bus.misalign_fault} !== {m_pc, m_valid, m_flush, m_fault}) begin
        n_fail++;
        $display("FAIL random[%0d]: got pc=%h v=%b f=%b mf=%b want pc=%h v=%b f=%b mf=%b", i,
                 bus.pc, bus.pc_valid, bus.flush, bus.misalign_fault, m_pc, m_valid, m_flush, m_fault);
      end
    end
    rst_n = 1;
  endtask

  initial begin
    idle(0);
    test_reset();
    test_jalr_misalign();
    test_priority();
    test_stall_redirect();
    test_wrap();
    test_fault_hold();
    test_reset_mid_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
